// File: rtl/memory_ctrl_pkg.sv
// Shared definitions for the memory controller slice.
//   state_t        : controller FSM states (bulk initialise, normal service)
//   WM_*           : write-mode selectors for the RAM (read-first / write-first)
//   RD_LAT_MIN/MAX : legal range of the response latency parameter
package memory_ctrl_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int WM_READ_FIRST  = 0;
    localparam int WM_WRITE_FIRST = 1;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

endpackage

// File: rtl/memory_ctrl_if.sv
// Request/response bus between the datapath FSM (master) and memory_ctrl (slave).
//   init_req / init_busy              : bulk initialise trigger and status
//   req_valid / req_ready / req_we    : request handshake and direction
//   req_addr / req_wdata              : request word address and write data
//   rsp_valid / rsp_rdata / rsp_err   : response strobe, data and out-of-range flag
// DATA_W and ADDR_W must match the parameters of the memory_ctrl instance.
interface memory_ctrl_if #(
    parameter int DATA_W = 9,
    parameter int ADDR_W = 13
);

    logic              init_req;
    logic              init_busy;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output init_req, req_valid, req_we, req_addr, req_wdata,
        input  init_busy, req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  init_req, req_valid, req_we, req_addr, req_wdata,
        output init_busy, req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/memory_ctrl_mem_array.sv
// mem_array: plain single-port synchronous RAM written to infer block RAM.
//   clka : clock (rising edge)
//   en   : read enable; dout is only updated on cycles with en=1
//   we   : write enable (independent of en so bulk writes leave dout untouched)
//   addr : word address, must be < DEPTH whenever en or we is high
//   din  : write data
//   dout : registered read data (old word in read-first, din in write-first)
module mem_array
    import memory_ctrl_pkg::*;
#(
    parameter int DATA_W     = 9,
    parameter int ADDR_W     = 13,
    parameter int DEPTH      = 8192,
    parameter int WRITE_MODE = WM_READ_FIRST
) (
    input  logic              clka,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset on the array or its output register so the tools can map both into BRAM.
    always_ff @(posedge clka) begin
        if (we) begin
            mem[addr] <= din;
        end
        if (en) begin
            if ((WRITE_MODE == WM_WRITE_FIRST) && we) begin
                dout <= din;
            end else begin
                dout <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/memory_ctrl.sv
// memory_ctrl: single-port RAM controller for factorisation working storage.
//   clka   : clock, all logic on the rising edge
//   rsta_n : asynchronous active-low reset
//   bus    : memory_ctrl_if slave port (init, request and response signals)
// After reset the controller writes INIT_VAL to every word (DEPTH cycles), then serves
// one request per cycle. Each accepted request produces exactly one response RD_LAT
// cycles later; addresses >= DEPTH skip the RAM and answer with rsp_err=1, data 0.
module memory_ctrl
    import memory_ctrl_pkg::*;
#(
    parameter int              DATA_W     = 9,
    parameter int              ADDR_W     = 13,
    parameter int              DEPTH      = 8192,
    parameter int              RD_LAT     = 1,
    parameter int              WRITE_MODE = WM_READ_FIRST,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic          clka,
    input  logic          rsta_n,
    memory_ctrl_if.slave  bus
);

    generate
        if ((RD_LAT < RD_LAT_MIN) || (RD_LAT > RD_LAT_MAX) ||
            (DEPTH < 1) || (DEPTH > (1 << ADDR_W))) begin : g_bad_cfg
            $error("memory_ctrl: RD_LAT must be 1 or 2 and DEPTH must be 1..2**ADDR_W");
        end
    endgenerate

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    // One extra bit so DEPTH == 2**ADDR_W is representable in the range compare.
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] init_cnt, init_cnt_nxt;

    logic              accept;
    logic              in_range;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    logic              s1_valid;
    logic              s1_err;
    logic [DATA_W-1:0] s1_data;

    assign in_range = ({1'b0, bus.req_addr} < DEPTH_EXT);

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
        end
    end

    // The init sequence owns the RAM port while it runs; in RUN the user request drives it.
    // init_req has priority over a simultaneous request, so ready drops while it is high.
    always_comb begin
        state_nxt     = state;
        init_cnt_nxt  = init_cnt;
        bus.init_busy = 1'b0;
        bus.req_ready = 1'b0;
        accept        = 1'b0;
        ram_en        = 1'b0;
        ram_we        = 1'b0;
        ram_addr      = bus.req_addr;
        ram_din       = bus.req_wdata;

        case (state)
            ST_INIT: begin
                bus.init_busy = 1'b1;
                ram_we        = 1'b1;
                ram_addr      = init_cnt;
                ram_din       = INIT_VAL;
                if (init_cnt == LAST_ADDR) begin
                    state_nxt    = ST_RUN;
                    init_cnt_nxt = '0;
                end else begin
                    init_cnt_nxt = init_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                bus.req_ready = ~bus.init_req;
                accept        = bus.req_valid & ~bus.init_req;
                ram_en        = accept & in_range;
                ram_we        = accept & bus.req_we & in_range;
                if (bus.init_req) begin
                    state_nxt    = ST_INIT;
                    init_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt    = ST_INIT;
                init_cnt_nxt = '0;
            end
        endcase
    end

    mem_array #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .WRITE_MODE (WRITE_MODE)
    ) u_mem (
        .clka (clka),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (ram_din),
        .dout (ram_dout)
    );

    // Stage 1 lines up with the RAM output register.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
        end else begin
            s1_valid <= accept;
            s1_err   <= ~in_range;
        end
    end

    assign s1_data = s1_err ? '0 : ram_dout;

    // The output register doubles as the hold register so rdata/err keep their last
    // response value while rsp_valid is low, whatever the RAM output does meanwhile.
    generate
        if (RD_LAT == 1) begin : g_lat1
            logic [DATA_W-1:0] hold_data;
            logic              hold_err;

            always_ff @(posedge clka or negedge rsta_n) begin
                if (!rsta_n) begin
                    hold_data <= '0;
                    hold_err  <= 1'b0;
                end else if (s1_valid) begin
                    hold_data <= s1_data;
                    hold_err  <= s1_err;
                end
            end

            assign bus.rsp_valid = s1_valid;
            assign bus.rsp_rdata = s1_valid ? s1_data : hold_data;
            assign bus.rsp_err   = s1_valid ? s1_err  : hold_err;
        end else begin : g_lat2
            logic              out_valid;
            logic [DATA_W-1:0] out_data;
            logic              out_err;

            always_ff @(posedge clka or negedge rsta_n) begin
                if (!rsta_n) begin
                    out_valid <= 1'b0;
                    out_data  <= '0;
                    out_err   <= 1'b0;
                end else begin
                    out_valid <= s1_valid;
                    if (s1_valid) begin
                        out_data <= s1_data;
                        out_err  <= s1_err;
                    end
                end
            end

            assign bus.rsp_valid = out_valid;
            assign bus.rsp_rdata = out_data;
            assign bus.rsp_err   = out_err;
        end
    endgenerate

endmodule
